// File: rtl/freq_gen.sv
// Programmable square-wave generator: a restoring divider turns a frequency
// in Hz into a half-period count, and a toggle counter drives OUT.
module freq_gen #(
    parameter int CLK_HZ = 100000000,
    parameter int FREQ_W = 20,
    parameter int DIV_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              load,
    input  logic [FREQ_W-1:0] freq,
    output logic              ready,
    output logic              done,
    output logic              active,
    output logic              OUT
);

    localparam int BIT_W = $clog2(DIV_W + 1);
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic              accept;
    logic              zero_req;
    logic              start;
    logic              last;

    logic [FREQ_W:0]   div_d;
    logic [DIV_W-1:0]  div_n;
    logic [DIV_W-1:0]  div_q;
    logic [FREQ_W+1:0] div_r;
    logic [BIT_W-1:0]  bit_q;

    logic [FREQ_W+1:0] r_sh;
    logic              r_ge;
    logic [FREQ_W+1:0] r_nxt;
    logic [DIV_W-1:0]  q_fin;

    logic [DIV_W-1:0]  half_period;
    logic [DIV_W-1:0]  cnt_q;
    logic              out_q;
    logic              done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ready    = (state_q != DIVIDE);
        accept   = ready && load;
        zero_req = accept && (freq == '0);
        start    = accept && (freq != '0);
        last     = (state_q == DIVIDE) && (bit_q == BIT_W'(DIV_W));
        unique case (1'b1)
            zero_req: state_d = IDLE;
            start:    state_d = DIVIDE;
            last:     state_d = RUN;
            default:  ;
        endcase
    end

    // One restoring step: shift the next dividend bit into the remainder.
    always_comb begin
        r_sh  = {div_r[FREQ_W:0], div_n[DIV_W-1]};
        r_ge  = (r_sh >= {1'b0, div_d});
        r_nxt = r_ge ? (r_sh - {1'b0, div_d}) : r_sh;
        q_fin = (div_q == '0) ? DIV_W'(1) : div_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_d <= '0;
            div_n <= '0;
            div_q <= '0;
            div_r <= '0;
            bit_q <= '0;
        end else if (start) begin
            div_d <= {freq, 1'b0};
            div_n <= DIVIDEND;
            div_q <= '0;
            div_r <= '0;
            bit_q <= '0;
        end else if (state_q == DIVIDE && !last) begin
            div_r <= r_nxt;
            div_q <= {div_q[DIV_W-2:0], r_ge};
            div_n <= {div_n[DIV_W-2:0], 1'b0};
            bit_q <= bit_q + BIT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            half_period <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= zero_req || last;
            if (zero_req) begin
                half_period <= '0;
            end else if (last) begin
                half_period <= q_fin;
            end
        end
    end

    // The old half-period keeps running while a new one is being divided.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (!enable || zero_req) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else if (last) begin
            cnt_q <= '0;
        end else if (half_period != '0) begin
            if (cnt_q == half_period - DIV_W'(1)) begin
                cnt_q <= '0;
                out_q <= ~out_q;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

    assign done   = done_q;
    assign active = (half_period != '0);
    assign OUT    = out_q;

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen: vector table of frequencies plus
// hand-written sequences for re-load, enable gating, reset and freq=0.
module tb_freq_gen;

    localparam int FW = 26;

    logic          CLK;
    logic          RST;
    logic          enable;
    logic          load;
    logic [FW-1:0] freq;
    logic          ready;
    logic          done;
    logic          active;
    logic          OUT;

    int errors = 0;
    int checks = 0;

    freq_gen #(
        .CLK_HZ(100000000),
        .FREQ_W(FW),
        .DIV_W (32)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .enable(enable),
        .load  (load),
        .freq  (freq),
        .ready (ready),
        .done  (done),
        .active(active),
        .OUT   (OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned f;
        int unsigned half;
        bit          measure;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns cycles from accept edge to the edge that raised done, or -1.
    task automatic do_load(input int unsigned f, output int lat);
        freq = FW'(f);
        load = 1'b1;
        step();
        load = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_toggle(input int bound, output int n);
        logic lvl;
        lvl = OUT;
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            step();
            if (OUT != lvl) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int n;
        int bad;
        int chg_at;
        int chg_cnt;
        logic lvl;

        vecs[0] = '{1000000,  50,       1'b1};
        vecs[1] = '{2000000,  25,       1'b1};
        vecs[2] = '{50000000, 1,        1'b1};
        vecs[3] = '{60000000, 1,        1'b1};
        vecs[4] = '{300000,   166,      1'b1};
        vecs[5] = '{1048575,  47,       1'b1};
        vecs[6] = '{3,        16666666, 1'b0};

        RST = 1'b1;
        enable = 1'b1;
        load = 1'b0;
        freq = '0;
        repeat (3) step();
        RST = 1'b0;
        chk("rst_out", OUT, 0);
        chk("rst_ready", ready, 1);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done || OUT || !ready || active) bad++;
        end
        chk("idle_quiet", bad, 0);

        foreach (vecs[i]) begin
            freq = FW'(vecs[i].f);
            load = 1'b1;
            step();
            load = 1'b0;
            chk($sformatf("v%0d_ready_low", i), ready, 0);
            lat = -1;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (done) begin
                    lat = k;
                    break;
                end
            end
            chk($sformatf("v%0d_latency", i), lat, 33);
            chk($sformatf("v%0d_ready", i), ready, 1);
            chk($sformatf("v%0d_active", i), active, 1);
            if (vecs[i].measure) begin
                wait_toggle(400, n);
                chk($sformatf("v%0d_first", i), n, vecs[i].half);
                wait_toggle(400, n);
                chk($sformatf("v%0d_half", i), n, vecs[i].half);
            end else begin
                chk($sformatf("v%0d_half_reg", i), dut.half_period, vecs[i].half);
            end
        end

        // Re-load 2 MHz while running at 1 MHz; a second load is ignored.
        do_load(1000000, lat);
        chk("rl_lat1", lat, 33);
        wait_toggle(200, n);
        repeat (29) step();
        lvl = OUT;
        freq = FW'(2000000);
        load = 1'b1;
        step();
        load = 1'b0;
        lat = -1;
        chg_at = -1;
        chg_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                freq = FW'(7);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
            if (k == 10) chk("rl_busy", ready, 0);
            if (OUT != lvl) begin
                chg_cnt++;
                chg_at = k;
                lvl = OUT;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        load = 1'b0;
        chk("rl_old_toggle_at", chg_at, 20);
        chk("rl_old_toggles", chg_cnt, 1);
        chk("rl_lat2", lat, 33);
        wait_toggle(200, n);
        chk("rl_new_first", n, 25);
        wait_toggle(200, n);
        chk("rl_new_half", n, 25);

        // Enable low for 200 cycles, then first rise 50 cycles later.
        do_load(1000000, lat);
        chk("en_lat", lat, 33);
        repeat (17) step();
        enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (OUT) bad++;
        end
        chk("en_low_out", bad, 0);
        chk("en_low_active", active, 1);
        enable = 1'b1;
        wait_toggle(200, n);
        chk("en_first_rise", n, 50);
        chk("en_rise_level", OUT, 1);

        // Reset in the middle of a division.
        freq = FW'(1000000);
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (10) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rd_out", OUT, 0);
        chk("rd_active", active, 0);
        chk("rd_ready", ready, 1);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done || OUT || active) bad++;
        end
        chk("rd_quiet", bad, 0);

        // Load freq=0 while running.
        do_load(1000000, lat);
        chk("z_lat", lat, 33);
        repeat (70) step();
        freq = '0;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("z_done", done, 1);
        chk("z_active", active, 0);
        chk("z_out", OUT, 0);
        chk("z_ready", ready, 1);
        step();
        chk("z_done_pulse", done, 0);
        bad = 0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (OUT || done || active) bad++;
        end
        chk("z_held", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
